// File: rtl/logic_pkg.sv
// Shared op codes and FSM state encodings for the NOR-unit arbiter.
package logic_pkg;

  localparam int unsigned OP_W = 2;
  localparam int unsigned ST_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOR  = 2'b00,
    OP_OR   = 2'b01,
    OP_AND  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/nor_logic_unit.sv
// Combinational 2-input bitwise logic unit; every op is composed from NOR terms.
module nor_logic_unit
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_sel,
  output logic [WIDTH-1:0] o_y_c
);

  logic [WIDTH-1:0] w_nab;
  logic [WIDTH-1:0] w_naa;
  logic [WIDTH-1:0] w_nbb;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_nand;

  // NOR network: OR and AND are built from inverted NORs, NAND inverts AND
  assign w_nab  = ~(i_a | i_b);
  assign w_or   = ~(w_nab | w_nab);
  assign w_naa  = ~(i_a | i_a);
  assign w_nbb  = ~(i_b | i_b);
  assign w_and  = ~(w_naa | w_nbb);
  assign w_nand = ~(w_and | w_and);

  // Select the requested op result
  always_comb begin
    o_y_c = w_nab;
    case (i_sel)
      OP_NOR:  o_y_c = w_nab;
      OP_OR:   o_y_c = w_or;
      OP_AND:  o_y_c = w_and;
      OP_NAND: o_y_c = w_nand;
      default: o_y_c = w_nab;
    endcase
  end

endmodule

// File: rtl/nor_unit_arbiter.sv
// Round-robin arbiter sharing one registered NOR logic unit between NREQ requesters.
module nor_unit_arbiter
  import logic_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_op_a,
  input  logic [NREQ*WIDTH-1:0] i_op_b,
  input  logic [NREQ*OP_W-1:0]  i_op_sel,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_busy,
  output logic                  o_res_valid,
  output logic [WIDTH-1:0]      o_res_data,
  output logic [IDW-1:0]        o_res_id
);

  // One extra bit so ptr+1+offset never wraps before the modulo correction
  localparam int unsigned PW = IDW + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  op_e               r_sel;
  logic [NREQ-1:0]   r_gnt;
  logic              r_busy;
  logic              r_res_valid;
  logic [WIDTH-1:0]  r_res_data;
  logic [IDW-1:0]    r_res_id;

  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic [PW-1:0]     w_shift;
  logic [PW-1:0]     w_sum;
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [OP_W-1:0]   w_sel;
  logic [WIDTH-1:0]  w_y;
  logic              w_latch;
  logic              w_capture;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic              w_busy_nxt;
  logic              w_valid_nxt;

  // Rotate requests so bit 0 is the requester right after the pointer
  assign w_req_dbl = {i_req, i_req};
  assign w_shift   = {1'b0, r_ptr} + PW'(1);
  assign w_req_rot = NREQ'(w_req_dbl >> w_shift);

  // Lowest set rotated bit wins; map its offset back to a requester index
  always_comb begin
    w_found = 1'b0;
    w_sum   = w_shift;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_found = 1'b1;
        w_sum   = w_shift + PW'(j);
      end
    end
    if (w_sum >= PW'(NREQ)) begin
      w_sum = w_sum - PW'(NREQ);
    end
    w_win = IDW'(w_sum);
  end

  // Steer the winner's operands and op code toward the latch
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a   = i_op_a[i*WIDTH +: WIDTH];
        w_b   = i_op_b[i*WIDTH +: WIDTH];
        w_sel = i_op_sel[i*OP_W +: OP_W];
      end
    end
  end

  nor_logic_unit #(
    .WIDTH (WIDTH)
  ) u_nor_logic_unit (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_sel (r_sel),
    .o_y_c (w_y)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the values the output registers take on the coming edge
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_latch     = 1'b1;
        end
      end
      S_GRANT: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_DONE;
        w_capture   = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_gnt_nxt   = (w_state_nxt == S_GRANT) ? (NREQ'(1) << w_win) : '0;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_valid_nxt = (w_state_nxt == S_DONE);
  end

  // Operand latch, RR pointer, registered outputs and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= OP_NOR;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_busy      <= w_busy_nxt;
      r_res_valid <= w_valid_nxt;
      if (w_latch) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_sel <= op_e'(w_sel);
        r_ptr <= w_win;
      end
      if (w_capture) begin
        r_res_data <= w_y;
        r_res_id   <= r_ptr;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_id    = r_res_id;

endmodule

// File: tb/tb_nor_unit_arbiter.sv
// Self-checking bench for nor_unit_arbiter: vector table, corner sequences, random traffic.
module tb_nor_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ*2-1:0]     op_sel;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;

  logic [WIDTH-1:0] ta [NREQ];
  logic [WIDTH-1:0] tb [NREQ];
  logic [1:0]       ts [NREQ];
  logic [NREQ-1:0]  nx_req;
  logic [WIDTH-1:0] nx_a [NREQ];
  logic [WIDTH-1:0] nx_b [NREQ];
  logic [1:0]       nx_s [NREQ];

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr;

  typedef struct {
    logic [NREQ-1:0]  req;
    int               id;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vt [6];

  nor_unit_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_op_sel    (op_sel),
    .o_gnt       (gnt),
    .o_busy      (busy),
    .o_res_valid (res_valid),
    .o_res_data  (res_data),
    .o_res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester operands onto the DUT buses
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i*WIDTH +: WIDTH] = ta[i];
      op_b[i*WIDTH +: WIDTH] = tb[i];
      op_sel[i*2 +: 2]       = ts[i];
    end
  end

  // Reference op semantics in plain boolean terms
  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] s, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (s)
      2'b00:   return ~(a | b);
      2'b01:   return a | b;
      2'b10:   return a & b;
      default: return ~(a & b);
    endcase
  endfunction

  // Reference round-robin pick: first requester after ptr, wrapping
  function automatic int ref_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    rst   = 1'b0;
    m_ptr = NREQ - 1;
  endtask

  // Run one transaction from IDLE; nx_* are applied in the gnt cycle
  task automatic txn(input string nm, input int exp_id, input logic [WIDTH-1:0] exp_d);
    int waited;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (gnt == '0 && waited < 8);
    chk({nm, "_gnt"}, 32'(gnt), 32'(1 << exp_id));
    chk({nm, "_lat"}, 32'(waited), 32'd1);
    req = nx_req;
    ta  = nx_a;
    tb  = nx_b;
    ts  = nx_s;
    @(posedge clk);
    #1;
    chk({nm, "_exec_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_exec_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_exec_busy"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 32'(res_valid), 32'd1);
    chk({nm, "_data"}, 32'(res_data), 32'(exp_d));
    chk({nm, "_id"}, 32'(res_id), 32'(exp_id));
    @(posedge clk);
    #1;
    chk({nm, "_valid_drop"}, 32'(res_valid), 32'd0);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_held_data"}, 32'(res_data), 32'(exp_d));
    m_ptr = exp_id;
  endtask

  task automatic keep_inputs(input logic [NREQ-1:0] r);
    nx_req = r;
    nx_a   = ta;
    nx_b   = tb;
    nx_s   = ts;
  endtask

  initial begin
    int w;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = '0;
      tb[i] = '0;
      ts[i] = '0;
    end
    rst = 1'b1;
    req = '0;

    vt[0] = '{req: 4'b0001, id: 0, sel: 2'b00, a: 8'hF0, b: 8'hCC, exp: 8'h03};
    vt[1] = '{req: 4'b0100, id: 2, sel: 2'b00, a: 8'hF0, b: 8'hCC, exp: 8'h03};
    vt[2] = '{req: 4'b0100, id: 2, sel: 2'b01, a: 8'hF0, b: 8'hCC, exp: 8'hFC};
    vt[3] = '{req: 4'b0100, id: 2, sel: 2'b10, a: 8'hF0, b: 8'hCC, exp: 8'hC0};
    vt[4] = '{req: 4'b0100, id: 2, sel: 2'b11, a: 8'hF0, b: 8'hCC, exp: 8'h3F};
    vt[5] = '{req: 4'b1000, id: 3, sel: 2'b01, a: 8'h0F, b: 8'hA0, exp: 8'hAF};

    // Reset values, then the vector table (first entry is the first op after reset)
    do_reset();
    for (int v = 0; v < 6; v++) begin
      ta[vt[v].id] = vt[v].a;
      tb[vt[v].id] = vt[v].b;
      ts[vt[v].id] = vt[v].sel;
      req = vt[v].req;
      keep_inputs('0);
      txn($sformatf("vec%0d", v), vt[v].id, vt[v].exp);
    end

    // No request: FSM stays idle
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // All requesting continuously: grants rotate 0,1,2,3,0,1
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = 8'(8'h11 * (i + 1));
      tb[i] = 8'h5A;
      ts[i] = 2'(i);
    end
    req = 4'b1111;
    keep_inputs(4'b1111);
    for (int k = 0; k < 6; k++) begin
      txn($sformatf("rr%0d", k), k % NREQ, ref_op(ts[k % NREQ], ta[k % NREQ], tb[k % NREQ]));
    end

    // Grant to 1, then req=1001 arriving after gnt: 3 next, then 0
    do_reset();
    req = 4'b0010;
    keep_inputs(4'b1001);
    txn("ptr1", 1, ref_op(ts[1], ta[1], tb[1]));
    keep_inputs(4'b0001);
    txn("ptr3", 3, ref_op(ts[3], ta[3], tb[3]));
    keep_inputs('0);
    txn("ptr0", 0, ref_op(ts[0], ta[0], tb[0]));

    // Reset during EXEC: no result, pointer restored, rst beats req
    do_reset();
    req = 4'b0010;
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (gnt == '0 && w < 8);
    chk("rx_gnt", 32'(gnt), 32'b0010);
    req = '0;
    @(posedge clk);
    #1;
    chk("rx_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    #1;
    chk("rx_valid", 32'(res_valid), 32'd0);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_data", 32'(res_data), 32'd0);
    @(posedge clk);
    #1;
    chk("rx_rst_wins", 32'(gnt), 32'd0);
    chk("rx_valid2", 32'(res_valid), 32'd0);
    rst = 1'b0;
    ta[0] = 8'h3C;
    tb[0] = 8'h0F;
    ts[0] = 2'b10;
    keep_inputs('0);
    txn("rx_after", 0, 8'h0C);

    // Operands of the winner change right after gnt: latched values used
    ta[2] = 8'hF0;
    tb[2] = 8'hCC;
    ts[2] = 2'b10;
    req   = 4'b0100;
    keep_inputs('0);
    nx_a[2] = 8'h00;
    nx_b[2] = 8'hFF;
    nx_s[2] = 2'b01;
    txn("latch", 2, 8'hC0);

    // Random traffic against the reference model; next request set lands in gnt cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = 8'($urandom);
      tb[i] = 8'($urandom);
      ts[i] = 2'($urandom);
    end
    req = 4'($urandom_range(1, 15));
    for (int it = 0; it < 40; it++) begin
      w = ref_pick(m_ptr, req);
      e = ref_op(ts[w], ta[w], tb[w]);
      nx_req = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        nx_a[i] = 8'($urandom);
        nx_b[i] = 8'($urandom);
        nx_s[i] = 2'($urandom);
      end
      txn($sformatf("rnd%0d", it), w, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
